gpio_pad_ctrl: RTL



---
 rtl/gpio_pad_ctrl.sv | 125 ++++++++++++
 1 files changed

// File: rtl/gpio_pad_ctrl.sv
// GPIO pad bank controller: registered push-pull/open-drain drive, synchronized,
// debounced (GPIO_PAD_CTRL_DEBOUNCE_EN) and edge-detected input with irq pending bits.
module gpio_pad_ctrl #(
    parameter int NUM_PINS    = 8,
    parameter int SYNC_STAGES = 2,
    parameter int DEB_W       = 8
) (
    input  logic                clk_i,
    input  logic                rst_i,
    input  logic [NUM_PINS-1:0] dir_i,
    input  logic [NUM_PINS-1:0] od_i,
    input  logic [NUM_PINS-1:0] out_i,
    input  logic [DEB_W-1:0]    deb_lim_i,
    input  logic [NUM_PINS-1:0] irq_en_i,
    input  logic [NUM_PINS-1:0] irq_rise_i,
    input  logic [NUM_PINS-1:0] irq_fall_i,
    input  logic [NUM_PINS-1:0] irq_clr_i,
    input  logic [NUM_PINS-1:0] pad_p2c_i,
    output logic [NUM_PINS-1:0] pad_c2p_o,
    output logic [NUM_PINS-1:0] pad_c2p_en_o,
    output logic [NUM_PINS-1:0] in_o,
    output logic [NUM_PINS-1:0] rise_o,
    output logic [NUM_PINS-1:0] fall_o,
    output logic [NUM_PINS-1:0] irq_pend_o,
    output logic                irq_o
);

    logic [NUM_PINS-1:0] r_c2p;
    logic [NUM_PINS-1:0] r_c2p_en;
    logic [NUM_PINS-1:0] r_sync [SYNC_STAGES];
    logic [NUM_PINS-1:0] w_sync;
    logic [NUM_PINS-1:0] r_stable;
    logic [NUM_PINS-1:0] r_prev;
    logic [NUM_PINS-1:0] r_pend;
    logic [NUM_PINS-1:0] w_rise;
    logic [NUM_PINS-1:0] w_fall;
    logic [NUM_PINS-1:0] w_set;

    // Open-drain only ever drives low; a 1 releases the pad.
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            r_c2p    <= '0;
            r_c2p_en <= '0;
        end else begin
            r_c2p    <= dir_i & ~od_i & out_i;
            r_c2p_en <= dir_i & ~(od_i & out_i);
        end
    end

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            for (int s = 0; s < SYNC_STAGES; s++) begin
                r_sync[s] <= '0;
            end
        end else begin
            r_sync[0] <= pad_p2c_i;
            for (int s = 1; s < SYNC_STAGES; s++) begin
                r_sync[s] <= r_sync[s-1];
            end
        end
    end

    assign w_sync = r_sync[SYNC_STAGES-1];

`ifdef GPIO_PAD_CTRL_DEBOUNCE_EN
    logic [DEB_W-1:0] r_cnt [NUM_PINS];

    // Any return of sync to stable restarts the count from zero.
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            r_stable <= '0;
            for (int p = 0; p < NUM_PINS; p++) begin
                r_cnt[p] <= '0;
            end
        end else begin
            for (int p = 0; p < NUM_PINS; p++) begin
                if (w_sync[p] == r_stable[p]) begin
                    r_cnt[p] <= '0;
                end else if (r_cnt[p] == deb_lim_i) begin
                    r_stable[p] <= w_sync[p];
                    r_cnt[p]    <= '0;
                end else begin
                    r_cnt[p] <= r_cnt[p] + 1'b1;
                end
            end
        end
    end
`else
    logic w_unused_deb;

    assign w_unused_deb = ^deb_lim_i;

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            r_stable <= '0;
        end else begin
            r_stable <= w_sync;
        end
    end
`endif

    assign w_rise = r_stable & ~r_prev;
    assign w_fall = ~r_stable & r_prev;
    assign w_set  = (w_rise & irq_rise_i) | (w_fall & irq_fall_i);

    // A new edge outranks a simultaneous clear.
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            r_prev <= '0;
            r_pend <= '0;
        end else begin
            r_prev <= r_stable;
            r_pend <= (r_pend & ~irq_clr_i) | w_set;
        end
    end

    assign pad_c2p_o    = r_c2p;
    assign pad_c2p_en_o = r_c2p_en;
    assign in_o         = r_stable;
    assign rise_o       = w_rise;
    assign fall_o       = w_fall;
    assign irq_pend_o   = r_pend;
    assign irq_o        = |(r_pend & irq_en_i);

endmodule
